// File: rtl/if_id_pkg.sv
// Shared fetch->decode types and constants.
// Defines the queued fetch entry layout and the sequential pc step.
package if_id_pkg;

    localparam int XLEN    = 32;
    localparam int ILEN    = 32;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic            bp_taken;
        logic [XLEN-1:0] bp_target;
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/wrap_ctr.sv
// Clear/increment counter that wraps MAX -> 0 explicitly.
// Ports: clk, rst (sync, active-high), clr, inc, q (current value).
module wrap_ctr #(
    parameter int MAX = 1,
    parameter int W   = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Explicit wrap so a non-power-of-two range is honoured.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            q_d = (q_q == W'(MAX)) ? '0 : q_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/if_id_queue.sv
// DEPTH-entry valid/ready queue between fetch and decode with flush.
// Ports: clk, rst, flush; in_* fetch side (in_ready registered);
//        out_* decode side (head, gated by out_valid); count occupancy.
module if_id_queue
    import if_id_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = if_id_pkg::XLEN,
    parameter int ILEN  = if_id_pkg::ILEN,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [ILEN-1:0] in_inst,
    input  logic            in_bp_taken,
    input  logic [XLEN-1:0] in_bp_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_p4,
    output logic [ILEN-1:0] out_inst,
    output logic            out_bp_taken,
    output logic [XLEN-1:0] out_bp_target,
    output logic [CW-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          in_ready_q;
    logic          in_ready_d;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push;
    logic          pop;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  wr_entry;
    fetch_entry_t  head;

    assign out_valid = (count_q != '0);
    assign in_ready  = in_ready_q;
    assign push      = in_valid & in_ready_q & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    wrap_ctr #(.MAX(DEPTH - 1), .W(PW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (push),
        .q   (wr_ptr)
    );

    wrap_ctr #(.MAX(DEPTH - 1), .W(PW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (pop),
        .q   (rd_ptr)
    );

    // Occupancy kept separately so full and empty never alias.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Registered ready: a pop while full frees the slot next cycle.
    assign in_ready_d = (count_d != CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        wr_entry           = '0;
        wr_entry.bp_taken  = in_bp_taken;
        wr_entry.bp_target = in_bp_target;
        wr_entry.pc        = in_pc;
        wr_entry.inst      = in_inst;
    end

    // Data array is not reset; out_valid masks stale slots.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= wr_entry;
        end
    end

    assign head = mem_q[rd_ptr];

    assign out_pc        = out_valid ? head.pc : '0;
    assign out_pc_p4     = out_valid ? head.pc + XLEN'(PC_STEP) : '0;
    assign out_inst      = out_valid ? head.inst : '0;
    assign out_bp_taken  = out_valid & head.bp_taken;
    assign out_bp_target = out_valid ? head.bp_target : '0;
    assign count         = count_q;

endmodule
